// File: rtl/gpr_file_sb.sv
// ---------------------------------------------------------------------------
// gpr_file_sb
//   General-purpose register file with a per-register scoreboard. Decode/issue
//   marks a destination register pending. Writeback writes the data and clears
//   the pending flag. Decode stalls on operands that report busy.
//
// Optional feature macro: GPR_BYPASS_EN
//   defined   : a write in flight is forwarded to the read ports in the same
//               cycle (data = wr_data, busy = 0). iss_ok also treats a pending
//               register that is being written this cycle as free.
//   undefined : reads and iss_ok see only the pre-edge array and pend state.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset (clears data, pend, pend_cnt)
//   wr_en      writeback strobe; wr_addr / wr_data select register and data
//   iss_en     issue strobe; marks iss_addr pending when iss_ok is high
//   iss_ok     comb: iss_addr is in range and not pending
//   rd_addr_a  read port A address -> rd_data_a / rd_busy_a (combinational)
//   rd_addr_b  read port B address -> rd_data_b / rd_busy_b (combinational)
//   pend_cnt   registered popcount of the pend vector
// ---------------------------------------------------------------------------
module gpr_file_sb #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 4,
  parameter int ZERO_R0  = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              iss_ok,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  output logic              rd_busy_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_b,
  output logic [ADDR_W:0]   pend_cnt
);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_pend;
  logic [ADDR_W:0]     r_pendCnt;

  logic [NUM_REGS-1:0] w_wrHit;
  logic                w_wrValid;
  logic                w_issPend;
  logic                w_issInRange;
  logic                w_issIsZero;
  logic                w_issByp;
  logic                w_issValid;
  logic [NUM_REGS-1:0] w_pendNext;
  logic [ADDR_W:0]     w_cntNext;

  // Address decode. An out-of-range address matches no index, so it
  // naturally becomes a no-op write and an out-of-range issue. A hardwired
  // r0 never produces a write hit.
  always_comb begin
    w_wrHit      = '0;
    w_issPend    = 1'b0;
    w_issInRange = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_wrHit[i] = wr_en && (wr_addr == ADDR_W'(i)) && !((ZERO_R0 != 0) && (i == 0));
      if (iss_addr == ADDR_W'(i)) begin
        w_issInRange = 1'b1;
        w_issPend    = r_pend[i];
      end
    end
  end

  assign w_wrValid   = |w_wrHit;
  assign w_issIsZero = (ZERO_R0 != 0) && (iss_addr == '0);

`ifdef GPR_BYPASS_EN
  assign w_issByp = w_wrValid && (wr_addr == iss_addr);
`else
  assign w_issByp = 1'b0;
`endif

  // A hardwired r0 is never pending, so it reports iss_ok=1. The issue
  // itself is then dropped by w_issIsZero.
  assign iss_ok     = w_issInRange && (!w_issPend || w_issByp);
  assign w_issValid = iss_en && iss_ok && !w_issIsZero;

  // Next pend vector: the write clears first, then the issue sets, so the
  // issue wins on a same-address collision. The count is recomputed from
  // the next vector, which keeps it equal to the popcount by construction.
  always_comb begin
    w_pendNext = r_pend;
    w_cntNext  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_wrHit[i]) begin
        w_pendNext[i] = 1'b0;
      end
      if (w_issValid && (iss_addr == ADDR_W'(i))) begin
        w_pendNext[i] = 1'b1;
      end
      w_cntNext = w_cntNext + {{ADDR_W{1'b0}}, w_pendNext[i]};
    end
  end

  // Combinational read ports. Out-of-range addresses read 0 / not busy.
  always_comb begin
    rd_data_a = '0;
    rd_busy_a = 1'b0;
    rd_data_b = '0;
    rd_busy_b = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr_a == ADDR_W'(i)) begin
        rd_data_a = r_regs[i];
        rd_busy_a = r_pend[i];
      end
      if (rd_addr_b == ADDR_W'(i)) begin
        rd_data_b = r_regs[i];
        rd_busy_b = r_pend[i];
      end
    end
`ifdef GPR_BYPASS_EN
    if (w_wrValid && (wr_addr == rd_addr_a)) begin
      rd_data_a = wr_data;
      rd_busy_a = 1'b0;
    end
    if (w_wrValid && (wr_addr == rd_addr_b)) begin
      rd_data_b = wr_data;
      rd_busy_b = 1'b0;
    end
`endif
  end

  // State update: register data, pend vector and pending count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend    <= '0;
      r_pendCnt <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_pend    <= w_pendNext;
      r_pendCnt <= w_cntNext;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wrHit[i]) begin
          r_regs[i] <= wr_data;
        end
      end
    end
  end

  assign pend_cnt = r_pendCnt;

endmodule
